// File: rtl/riscv_base_mul_writeback_if.sv
// Signal bundle between the multiply/ALU writeback stage and its neighbours.
// The master modport drives the issue, result and decode side. The slave modport is the writeback stage.
interface riscv_base_mul_writeback_if;
  logic        hold_i;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_idx_i;
  logic [31:0] mul_value_i;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_idx_i;
  logic [31:0] alu_value_i;
  logic [4:0]  dec_ra_idx_i;
  logic [4:0]  dec_rb_idx_i;
  logic [4:0]  dec_rd_idx_i;
  logic        rf_we_o;
  logic [4:0]  rf_rd_idx_o;
  logic [31:0] rf_value_o;
  logic        stall_o;

  modport master (
    output hold_i, issue_valid_i, issue_rd_idx_i, mul_value_i,
           alu_valid_i, alu_rd_idx_i, alu_value_i,
           dec_ra_idx_i, dec_rb_idx_i, dec_rd_idx_i,
    input  rf_we_o, rf_rd_idx_o, rf_value_o, stall_o
  );

  modport slave (
    input  hold_i, issue_valid_i, issue_rd_idx_i, mul_value_i,
           alu_valid_i, alu_rd_idx_i, alu_value_i,
           dec_ra_idx_i, dec_rb_idx_i, dec_rd_idx_i,
    output rf_we_o, rf_rd_idx_o, rf_value_o, stall_o
  );
endinterface

// File: rtl/riscv_base_mul_writeback.sv
// Pairs pipelined-multiplier results with their destination registers and merges them with ALU results.
// The merged results go to one registered register-file write port. A one-entry skid buffer absorbs collisions.
module riscv_base_mul_writeback #(
  parameter int unsigned MULT_STAGES = 2
) (
  input logic                          clk_i,
  input logic                          rst_ni,
  riscv_base_mul_writeback_if.slave    bus
);

  localparam int unsigned TAIL = MULT_STAGES - 1;

  logic [MULT_STAGES-1:0] trk_vld_q, trk_vld_d;
  logic [4:0]             trk_rd_q [MULT_STAGES];
  logic [4:0]             trk_rd_d [MULT_STAGES];

  logic        skid_vld_q, skid_vld_d;
  logic [4:0]  skid_rd_q,  skid_rd_d;
  logic [31:0] skid_val_q, skid_val_d;

  logic        rf_we_q,  rf_we_d;
  logic [4:0]  rf_rd_q,  rf_rd_d;
  logic [31:0] rf_val_q, rf_val_d;

  logic alu_ok;
  logic stall;

  assign alu_ok = bus.alu_valid_i && (bus.alu_rd_idx_i != '0);

  function automatic logic dec_hit(input logic [4:0] rd,
                                   input logic [4:0] ra,
                                   input logic [4:0] rb,
                                   input logic [4:0] rdd);
    return ((ra  != '0) && (ra  == rd)) ||
           ((rb  != '0) && (rb  == rd)) ||
           ((rdd != '0) && (rdd == rd));
  endfunction

  always_comb begin
    trk_vld_d  = trk_vld_q;
    trk_rd_d   = trk_rd_q;
    skid_vld_d = skid_vld_q;
    skid_rd_d  = skid_rd_q;
    skid_val_d = skid_val_q;
    rf_we_d    = rf_we_q;
    rf_rd_d    = rf_rd_q;
    rf_val_d   = rf_val_q;

    if (!bus.hold_i) begin
      trk_vld_d[0] = bus.issue_valid_i && (bus.issue_rd_idx_i != '0);
      trk_rd_d[0]  = bus.issue_rd_idx_i;
      for (int unsigned i = 1; i < MULT_STAGES; i++) begin
        trk_vld_d[i] = trk_vld_q[i-1];
        trk_rd_d[i]  = trk_rd_q[i-1];
      end

      rf_we_d = 1'b0;
      // The multiplier result cannot wait because the multiplier has already moved on. An ALU result that collides with it is parked in the skid buffer.
      if (trk_vld_q[TAIL]) begin
        rf_we_d  = 1'b1;
        rf_rd_d  = trk_rd_q[TAIL];
        rf_val_d = bus.mul_value_i;
        if (alu_ok) begin
          skid_vld_d = 1'b1;
          skid_rd_d  = bus.alu_rd_idx_i;
          skid_val_d = bus.alu_value_i;
        end
      end else if (skid_vld_q) begin
        rf_we_d    = 1'b1;
        rf_rd_d    = skid_rd_q;
        rf_val_d   = skid_val_q;
        skid_vld_d = alu_ok;
        if (alu_ok) begin
          skid_rd_d  = bus.alu_rd_idx_i;
          skid_val_d = bus.alu_value_i;
        end
      end else if (alu_ok) begin
        rf_we_d  = 1'b1;
        rf_rd_d  = bus.alu_rd_idx_i;
        rf_val_d = bus.alu_value_i;
      end
    end
  end

  // A valid skid entry stalls unconditionally, so its rd does not need a separate hazard compare.
  always_comb begin
    stall = skid_vld_q;
    for (int unsigned i = 0; i < MULT_STAGES; i++) begin
      if (trk_vld_q[i] &&
          dec_hit(trk_rd_q[i], bus.dec_ra_idx_i, bus.dec_rb_idx_i, bus.dec_rd_idx_i)) begin
        stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trk_vld_q  <= '0;
      trk_rd_q   <= '{default: '0};
      skid_vld_q <= 1'b0;
      skid_rd_q  <= '0;
      skid_val_q <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_val_q   <= '0;
    end else begin
      trk_vld_q  <= trk_vld_d;
      trk_rd_q   <= trk_rd_d;
      skid_vld_q <= skid_vld_d;
      skid_rd_q  <= skid_rd_d;
      skid_val_q <= skid_val_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_val_q   <= rf_val_d;
    end
  end

  assign bus.rf_we_o     = rf_we_q;
  assign bus.rf_rd_idx_o = rf_rd_q;
  assign bus.rf_value_o  = rf_val_q;
  assign bus.stall_o     = stall;

  a_no_skid_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(!bus.hold_i && skid_vld_q && trk_vld_q[TAIL] && alu_ok));

endmodule
